// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the data-memory arbiter.
// FSM state enum, master id type, master constants, grant helper.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef logic mid_t;

  localparam mid_t MASTER_CPU = 1'b0;
  localparam mid_t MASTER_DMA = 1'b1;

  // On contention the master that was not served last wins.
  function automatic mid_t pick(
    input logic r0,
    input logic r1,
    input mid_t last
  );
    if (r0 && r1) return mid_t'(~last);
    else if (r1)  return MASTER_DMA;
    else          return MASTER_CPU;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: saturating ACCESS-cycle counter for the arbiter abort.
// Ports: clk, reset (async active-low), clear, en, expired (LIMIT-th cycle).
module mem_arb_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] cnt;

  // cnt holds the number of ACCESS cycles already spent,
  // so the LIMIT-th cycle is the one with cnt == LIMIT-1.
  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin 2-master arbiter for the data-memory port.
// Ports: clk, reset (async low), m0/m1 req/wr/addr/wdata/ack/err,
//   m_rdata, mem_req/wr/addr/wdata/ready/rdata.
//   MEM_ARB_TIMEOUT_EN adds the TIMEOUT-cycle abort with err=1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  state_t state, state_nx;
  mid_t   owner, owner_nx;
  mid_t   last, last_nx;

  logic access;
  logic done;
  logic abort;
  logic fin;
  logic is_dma;
  logic other_req;

  assign access = (state == ACCESS);
  assign is_dma = (owner == MASTER_DMA);
  assign done   = access && mem_ready;
  assign fin    = done || abort;

  // The just-served master is masked: only the other one
  // can keep the port busy without an IDLE cycle.
  assign other_req = is_dma ? m0_req : m1_req;

`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;
  logic tmr_clear;

  assign tmr_clear = !access || fin;

  mem_arb_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .en      (access),
    .expired (expired)
  );

  // A real completion in the same cycle beats the abort.
  assign abort = access && expired && !mem_ready;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= MASTER_CPU;
      last  <= MASTER_DMA;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nx = ACCESS;
          owner_nx = pick(m0_req, m1_req, last);
        end
      end
      ACCESS: begin
        if (fin) begin
          last_nx = owner;
          if (other_req) owner_nx = mid_t'(~owner);
          else           state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_req   = access;
  assign mem_wr    = access && (is_dma ? m1_wr : m0_wr);
  assign mem_addr  = is_dma ? m1_addr : m0_addr;
  assign mem_wdata = is_dma ? m1_wdata : m0_wdata;

  assign m0_ack  = fin && !is_dma;
  assign m1_ack  = fin && is_dma;
  assign m0_err  = abort && !is_dma;
  assign m1_err  = abort && is_dma;
  assign m_rdata = done ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Directed vectors; a monitor pops expected acks and cycle probes.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_wr, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata;
  logic [31:0] m_rdata;
  logic        mem_req, mem_wr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int lat   = 0;
  bit stall = 1'b0;
  bit kill  = 1'b0;
  int wcnt  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_wr     (m0_wr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_wr     (m1_wr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .m_rdata   (m_rdata),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: ready after lat waiting cycles of one access.
  assign mem_ready = mem_req && !stall && (wcnt >= lat);
  assign mem_rdata = rd_of(mem_addr);

  always @(posedge clk) begin
    if (!mem_req || m0_ack || m1_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    bit          chk_rd;
    logic        err;
    int          gap;
  } exp_t;

  typedef enum int {
    K_REQ, K_WR, K_ADDR, K_WDATA, K_ACK, K_ERR, K_RDATA, K_SB
  } kind_t;

  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] val;
  } probe_t;

  tx_t    q0[$];
  tx_t    q1[$];
  exp_t   sb[$];
  probe_t pq[$];

  int n_cmp    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int last_ack = 0;

  function automatic logic [31:0] sample(input kind_t k);
    case (k)
      K_REQ:   return {31'b0, mem_req};
      K_WR:    return {31'b0, mem_wr};
      K_ADDR:  return mem_addr;
      K_WDATA: return mem_wdata;
      K_ACK:   return {30'b0, m1_ack, m0_ack};
      K_ERR:   return {30'b0, m1_err, m0_err};
      K_RDATA: return m_rdata;
      K_SB:    return 32'(sb.size());
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: probes for this cycle, then any ack against the scoreboard.
  initial begin
    probe_t      p;
    exp_t        e;
    logic [31:0] act;
    int          id;
    logic        err;
    bit          ok;
    forever begin
      @(negedge clk);
      cyc++;
      while (pq.size() > 0) begin
        p   = pq.pop_front();
        act = sample(p.kind);
        n_cmp++;
        if (act !== p.val) begin
          n_bad++;
          $display("FAIL %s: got %h want %h", p.name, act, p.val);
        end
      end
      if (m0_ack || m1_ack) begin
        id  = m1_ack ? 1 : 0;
        err = m1_ack ? m1_err : m0_err;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL stray_ack: got ack m%0d want none", id);
        end else begin
          e  = sb.pop_front();
          ok = (id == e.id) && (err === e.err) &&
               !(m0_ack && m1_ack) &&
               (!e.chk_rd || m_rdata === e.rdata) &&
               (e.gap == 0 || cyc - last_ack == e.gap);
          if (!ok) begin
            n_bad++;
            $display({"FAIL ack: got m%0d rd=%h err=%b gap=%0d",
                      " want m%0d rd=%h err=%b gap=%0d"},
                     id, m_rdata, err, cyc - last_ack,
                     e.id, e.rdata, e.err, e.gap);
          end
        end
        last_ack = cyc;
      end
    end
  end

  // Master driver: holds each request until its ack, then moves on.
  initial begin
    tx_t t;
    bit  a0, a1;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    forever begin
      @(negedge clk);
      a0 = m0_ack;
      a1 = m1_ack;
      @(posedge clk);
      #1;
      if (kill) begin
        m0_req = 0;
        m1_req = 0;
        q0.delete();
        q1.delete();
      end else begin
        if (a0) m0_req = 0;
        if (a1) m1_req = 0;
        if (!m0_req && q0.size() > 0) begin
          t = q0.pop_front();
          m0_req = 1; m0_wr = t.wr;
          m0_addr = t.addr; m0_wdata = t.wdata;
        end
        if (!m1_req && q1.size() > 0) begin
          t = q1.pop_front();
          m1_req = 1; m1_wr = t.wr;
          m1_addr = t.addr; m1_wdata = t.wdata;
        end
      end
    end
  end

  task automatic probe(input string n, input kind_t k,
                       input logic [31:0] v);
    probe_t p;
    p.name = n;
    p.kind = k;
    p.val  = v;
    pq.push_back(p);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_tx(input int m, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    tx_t t;
    t.wr = wr;
    t.addr = a;
    t.wdata = d;
    if (m == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic expect_ack(input int m, input logic [31:0] rd,
                            input bit chk, input logic err,
                            input int gap);
    exp_t e;
    e.id = m;
    e.rdata = rd;
    e.chk_rd = chk;
    e.err = err;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic drain(input string n, input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      step();
      k++;
    end
    probe(n, K_SB, 32'd0);
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    probe("rst_req", K_REQ, 32'd0);
    probe("rst_ack", K_ACK, 32'd0);
    probe("rst_err", K_ERR, 32'd0);
    probe("rst_rdata", K_RDATA, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    step();

    // Contention straight after reset: m0 first, m1 back-to-back.
    lat = 0;
    push_tx(0, 1'b0, 32'h100, 32'h0);
    push_tx(1, 1'b0, 32'h200, 32'h0);
    expect_ack(0, 32'hA5A5_0100, 1'b1, 1'b0, 0);
    expect_ack(1, 32'hA5A5_0200, 1'b1, 1'b0, 1);
    drain("contend_drain", 20);

    // Fairness: both keep requesting, strict alternation.
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      push_tx(0, 1'b0, 32'h1000 + 32'(4 * i), 32'h0);
      push_tx(1, 1'b0, 32'h2000 + 32'(4 * i), 32'h0);
      expect_ack(0, 32'hA5A5_1000 + 32'(4 * i), 1'b1, 1'b0,
                 (i == 0) ? 0 : 2);
      expect_ack(1, 32'hA5A5_2000 + 32'(4 * i), 1'b1, 1'b0, 2);
    end
    drain("fair_drain", 60);

    // Single read, ready in the first ACCESS cycle.
    lat = 0;
    push_tx(0, 1'b0, 32'h10, 32'h0);
    expect_ack(0, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
    probe("rd_c0_idle", K_REQ, 32'd0);
    step();
    probe("rd_c1_req", K_REQ, 32'd1);
    probe("rd_c1_ack", K_ACK, 32'd1);
    probe("rd_c1_data", K_RDATA, 32'hDEAD_BEEF);
    step();
    probe("rd_back_idle", K_REQ, 32'd0);
    probe("rd_no_ack", K_ACK, 32'd0);
    drain("rd_drain", 10);

    // Write with ready three cycles late.
    lat = 3;
    push_tx(1, 1'b1, 32'h20, 32'h0000_CAFE);
    expect_ack(1, 32'h0, 1'b0, 1'b0, 0);
    probe("wr_c0_idle", K_REQ, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      probe("wr_strobe", K_WR, 32'd1);
      probe("wr_addr", K_ADDR, 32'h20);
      probe("wr_wdata", K_WDATA, 32'h0000_CAFE);
      probe("wr_wait_ack", K_ACK, 32'd0);
      step();
    end
    probe("wr_ack", K_ACK, 32'd2);
    probe("wr_strobe_end", K_WR, 32'd1);
    step();
    drain("wr_drain", 10);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: both accesses abort after 4 cycles.
    lat = 0;
    stall = 1'b1;
    push_tx(0, 1'b0, 32'h30, 32'h0);
    push_tx(1, 1'b0, 32'h40, 32'h0);
    expect_ack(0, 32'h0, 1'b1, 1'b1, 0);
    expect_ack(1, 32'h0, 1'b1, 1'b1, 4);
    drain("tmo_drain", 40);
    probe("tmo_idle", K_REQ, 32'd0);
    step();
    stall = 1'b0;
`else
    // Without the abort the access just waits.
    lat = 0;
    stall = 1'b1;
    push_tx(0, 1'b0, 32'h30, 32'h0);
    repeat (20) step();
    probe("hold_req", K_REQ, 32'd1);
    probe("hold_ack", K_ACK, 32'd0);
    probe("hold_err", K_ERR, 32'd0);
    step();
    expect_ack(0, 32'hA5A5_0030, 1'b1, 1'b0, 0);
    stall = 1'b0;
    drain("hold_drain", 10);
`endif

    // Reset while an access is stalled.
    lat = 0;
    stall = 1'b1;
    push_tx(1, 1'b0, 32'h50, 32'h0);
    step();
    step();
    step();
    probe("pre_rst_req", K_REQ, 32'd1);
    step();
    @(posedge clk);
    #1;
    reset = 1'b0;
    kill = 1'b1;
    probe("mid_rst_req", K_REQ, 32'd0);
    probe("mid_rst_ack", K_ACK, 32'd0);
    probe("mid_rst_rdata", K_RDATA, 32'd0);
    step();
    step();
    step();
    reset = 1'b1;
    kill = 1'b0;
    stall = 1'b0;
    probe("post_rst_req", K_REQ, 32'd0);
    step();
    step();
    probe("post_rst_idle", K_REQ, 32'd0);
    probe("post_rst_sb", K_SB, 32'd0);
    step();

    // Reset restores last=1, so m0 wins again.
    push_tx(0, 1'b0, 32'h300, 32'h0);
    push_tx(1, 1'b0, 32'h400, 32'h0);
    expect_ack(0, 32'hA5A5_0300, 1'b1, 1'b0, 0);
    expect_ack(1, 32'hA5A5_0400, 1'b1, 1'b0, 1);
    drain("rst_contend_drain", 20);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
